// File: rtl/coin_start_sequencer.sv
// Coin/start switch sequencer: a start request produces a timed coin pulse, a gap,
// and a start pulse counted in video frames, then waits for the request to release.
module coin_start_sequencer #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic vblank,
  input  logic req_start1,
  input  logic req_start2,
  output logic coin,
  output logic start1,
  output logic start2,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_START,
    S_RELEASE
  } state_e;

  localparam logic [8:0] COIN_LAST  = 9'(COIN_FRAMES);
  localparam logic [8:0] GAP_LAST   = 9'(GAP_FRAMES);
  localparam logic [8:0] START_LAST = 9'(START_FRAMES);
  localparam logic       SKIP_GAP   = (GAP_FRAMES == 0);

  state_e     state_q, state_d;
  logic [7:0] fc_q, fc_d;
  logic       sel_q, sel_d;
  logic       vblank_q;
  logic       coin_q, coin_d;
  logic       start1_q, start1_d;
  logic       start2_q, start2_d;
  logic       busy_q, busy_d;

  logic       tick;
  logic [8:0] fc_inc;

  // One-cycle frame tick; a held vblank yields only the rising-edge tick.
  assign tick   = vblank & ~vblank_q;
  // Compare in 9 bits so the increment can never alias a parameter value.
  assign fc_inc = {1'b0, fc_q} + 9'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    sel_d   = sel_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_start1 || req_start2) begin
          sel_d   = ~req_start1;
          fc_d    = 8'd0;
          state_d = S_COIN;
        end
      end
      S_COIN: begin
        if (tick) begin
          if (fc_inc == COIN_LAST) begin
            fc_d    = 8'd0;
            state_d = SKIP_GAP ? S_START : S_GAP;
          end else begin
            fc_d = fc_inc[7:0];
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (fc_inc == GAP_LAST) begin
            fc_d    = 8'd0;
            state_d = S_START;
          end else begin
            fc_d = fc_inc[7:0];
          end
        end
      end
      S_START: begin
        if (tick) begin
          if (fc_inc == START_LAST) begin
            fc_d    = 8'd0;
            state_d = S_RELEASE;
          end else begin
            fc_d = fc_inc[7:0];
          end
        end
      end
      S_RELEASE: begin
        // Wait for both requests to drop so a held button cannot auto-repeat.
        if (!req_start1 && !req_start2) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    coin_d   = (state_d == S_COIN);
    start1_d = (state_d == S_START) && !sel_d;
    start2_d = (state_d == S_START) &&  sel_d;
    busy_d   = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      fc_q     <= 8'd0;
      sel_q    <= 1'b0;
      // NOTE: history resets high so a vblank already high at release is not a tick.
      vblank_q <= 1'b1;
      coin_q   <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      sel_q    <= sel_d;
      vblank_q <= vblank;
      coin_q   <= coin_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
      busy_q   <= busy_d;
    end
  end

  assign coin   = coin_q;
  assign start1 = start1_q;
  assign start2 = start2_q;
  assign busy   = busy_q;

endmodule
